gb_subbus_bridge: RTL
=====================

Name: gb_subbus_bridge

Overview:
- Parametrised successor to the single parent-to-child bus glue: one parent ghostbus port fans out to NCH child sub-busses.
- Each child owns a 2^SUB_AW-word window at BASE + k*2^SUB_AW.
- Child address is trimmed to SUB_AW bits, writes are strobed one-hot, and read data returns muxed at a fixed, documented latency.
- Sits between the top-level gb bus and generated child decoders; unmapped writes are counted for debug.

Parameters:
- AW, 24, parent address width.
- DW, 32, data width (parent and children).
- SUB_AW, 8, child window address width; window = 2^SUB_AW words.
- NCH, 4, number of child windows, 1..16.
- BASE, 0, parent word address of window 0; must be a multiple of 2^SUB_AW; BASE + NCH*2^SUB_AW <= 2^AW.
- CRL, 1, child read latency in cycles, 0..4. Child rdata is valid CRL cycles after c_addr changes.
- MW, 16, miss counter width.

Ports:
- clk  in  1  bus clock, all logic posedge.
- rst  in  1  synchronous active-high reset.
- p_addr  in  AW  parent address.
- p_wdata  in  DW  parent write data.
- p_wstb  in  1  parent write strobe; 0 means read.
- p_rdata  out  DW  parent read data.
- c_addr  out  SUB_AW  trimmed address, shared by all children.
- c_wdata  out  DW  write data, shared.
- c_wstb  out  NCH  one-hot write strobe.
- c_rdata  in  NCH*DW  child read data, channel k at [k*DW +: DW].
- miss_clr  in  1  clear miss counter.
- miss_cnt  out  MW  saturating count of unmapped writes.

Behaviour:
- Decode (combinational, cycle t):
  - off = p_addr[AW-1:SUB_AW] - BASE[AW-1:SUB_AW], computed at AW-SUB_AW width.
  - hit = (p_addr >= BASE) && (off < NCH).
  - idx = off[CW-1:0], with CW = max(1, clog2(NCH)).
- Request stage (registered, visible cycle t+1):
  - c_addr <= p_addr[SUB_AW-1:0] and c_wdata <= p_wdata, every cycle regardless of hit.
  - c_wstb <= (p_wstb && hit) ? (1 << idx) : 0. At most one bit is high, for exactly one cycle per parent strobe cycle.
- Read select pipeline:
  - A shift register of depth CRL+1 carries {rd_v, idx}; rd_v = hit && !p_wstb at cycle t.
  - The stage-0 entry is aligned with c_addr at t+1.
- Read return:
  - At cycle t+2+CRL, p_rdata <= rd_v ? c_rdata[idx] : 0, using the tail entry of the pipeline.
  - Total parent read latency RL = CRL+2, fixed and pipelined: one new read may be issued per cycle.
  - p_rdata holds its last value only until the next tail entry; tail entries exist every cycle, so a write or miss cycle yields 0.
- Write followed by read, same address, back to back:
  - The child sees the write at t+1 and the read address at t+2.
  - Read-after-write ordering is guaranteed by the single shared request stage.
- Miss counter:
  - At each cycle with p_wstb && !hit, miss_cnt increments, saturating at 2^MW-1.
  - miss_clr has priority over increment; a simultaneous miss is not counted.
  - Reads cannot be detected as misses (no read strobe); they return 0.
- Address edges:
  - p_addr = BASE-1 is a miss.
  - p_addr = BASE + NCH*2^SUB_AW - 1 hits channel NCH-1, c_addr all ones.
  - The subtraction must not wrap into a false hit when p_addr < BASE.
- Reset: c_addr, c_wdata, c_wstb, p_rdata, miss_cnt and all pipeline rd_v bits go to 0.
  - Reset mid-read: the in-flight read is dropped and p_rdata is 0 until a fresh read reaches the tail.
  - rst has priority over miss_clr.
- NCH = 1: idx is a constant 0; the hit test reduces to the window range check.

Decomposition:
- Shared package gb_bridge_pkg holds:
  - function clog2;
  - function win_hit(addr, base, sub_aw, nch);
  - localparam RL_OF(crl) = crl+2, for the generator and benches.
- One natural sub-module: gb_sel_pipe (parametrised DEPTH and W shift register with a synchronous clear), carrying {rd_v, idx}.
- All other logic stays flat in gb_subbus_bridge.

Test Plan:
- Defaults, write p_addr 0x000105 data 0xDEADBEEF -> at t+1, c_wstb = 4'b0010, c_addr = 0x05, c_wdata = 0xDEADBEEF, high for one cycle only.
- Read 0x000305 with child 3 driving 0x12345678 and CRL = 1 -> p_rdata = 0x12345678 exactly 3 cycles later. Reads to 0x000000/0x000100/0x000200/0x000300 on consecutive cycles return the four channel values on 4 consecutive cycles.
- Write to 0x000400 (just past the last window), BASE = 0 -> c_wstb stays 0 and miss_cnt increments to 1. A read of 0x000400 returns 0.
- BASE = 0x000200, write 0x0001FF -> miss, with no false hit from wrap. Write 0x0005FF -> c_wstb[3], c_addr = 0xFF.
- Saturation and priority:
  - MW = 4 with 20 miss writes -> miss_cnt = 15.
  - miss_clr asserted together with a miss -> miss_cnt = 0 the next cycle.
- Issue a read, assert rst for one cycle at t+1 -> p_rdata = 0 at t+3. Sweep CRL = 0 and CRL = 4 to confirm RL = 2 and RL = 6 respectively.

Source files
------------

// File: rtl/gb_bridge_pkg.sv
// rtl/gb_bridge_pkg.sv - shared helpers for the ghostbus sub-bus bridge
package gb_bridge_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Window hit test; the addr >= base guard keeps a below-base address from wrapping into a hit.
  function automatic logic win_hit(input logic [63:0] addr, input logic [63:0] base,
                                   input int sub_aw, input int nch);
    logic [63:0] off;
    off = (addr >> sub_aw) - (base >> sub_aw);
    return (addr >= base) && (off < 64'(nch));
  endfunction

  function automatic int RL_OF(input int crl);
    return crl + 2;
  endfunction

endpackage

// File: rtl/gb_sel_pipe.sv
// rtl/gb_sel_pipe.sv - fixed-depth shift register with synchronous clear
module gb_sel_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/gb_subbus_bridge.sv
// rtl/gb_subbus_bridge.sv - parent ghostbus port fanned out to NCH child windows
module gb_subbus_bridge
  import gb_bridge_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int SUB_AW = 8,
  parameter int NCH    = 4,
  parameter int BASE   = 0,
  parameter int CRL    = 1,
  parameter int MW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     p_addr,
  input  logic [DW-1:0]     p_wdata,
  input  logic              p_wstb,
  output logic [DW-1:0]     p_rdata,
  output logic [SUB_AW-1:0] c_addr,
  output logic [DW-1:0]     c_wdata,
  output logic [NCH-1:0]    c_wstb,
  input  logic [NCH*DW-1:0] c_rdata,
  input  logic              miss_clr,
  output logic [MW-1:0]     miss_cnt
);

  localparam int CW = (NCH > 1) ? clog2(NCH) : 1;
  localparam int OW = AW - SUB_AW;
  localparam logic [AW-1:0] BASE_A  = AW'(BASE);
  localparam logic [OW-1:0] BASE_HI = OW'(BASE >> SUB_AW);
  // One extra bit so NCH == 2^OW still compares correctly.
  localparam logic [OW:0]   NCH_W   = (OW+1)'(NCH);

  logic [OW-1:0] off;
  logic          hit;
  logic [CW-1:0] idx;
  logic          rd_v;

  assign off  = p_addr[AW-1:SUB_AW] - BASE_HI;
  assign hit  = (p_addr >= BASE_A) && ({1'b0, off} < NCH_W);
  assign idx  = (NCH == 1) ? '0 : off[CW-1:0];
  assign rd_v = hit && !p_wstb;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_addr  <= '0;
      c_wdata <= '0;
      c_wstb  <= '0;
    end else begin
      c_addr  <= p_addr[SUB_AW-1:0];
      c_wdata <= p_wdata;
      c_wstb  <= (p_wstb && hit) ? (NCH'(1) << idx) : '0;
    end
  end

  // Stage 0 lines up with c_addr; the tail lines up with child data CRL cycles later.
  logic [CW:0]   tail;
  logic          tail_v;
  logic [CW-1:0] tail_idx;

  gb_sel_pipe #(
    .DEPTH (CRL + 1),
    .W     (CW + 1)
  ) u_sel_pipe (
    .clk (clk),
    .clr (rst),
    .d   ({rd_v, idx}),
    .q   (tail)
  );

  assign tail_v   = tail[CW];
  assign tail_idx = tail[CW-1:0];

  logic [DW-1:0] sel_data;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++)
      if (tail_idx == CW'(k)) sel_data = c_rdata[k*DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (rst) p_rdata <= '0;
    else     p_rdata <= tail_v ? sel_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || miss_clr)
      miss_cnt <= '0;
    else if (p_wstb && !hit && (miss_cnt != '1))
      miss_cnt <= miss_cnt + 1'b1;
  end

endmodule
